// File: rtl/paralelo_serial_if.sv
// Byte-stream handshake into the serializer and the serial-link outputs it drives.
// The master side is the upstream byte source; the slave side is the serializer.
interface paralelo_serial_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready_out;
  logic              data_out;
  logic              active_out;
  logic              sync_out;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out,
    input  data_out,
    input  active_out,
    input  sync_out
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out,
    output data_out,
    output active_out,
    output sync_out
  );
endinterface

// File: rtl/paralelo_serial_tx.sv
// Byte-to-bit serializer: sends NUM_COMMA alignment commas after reset, then
// forwards upstream bytes MSB first, filling empty frames with COMMA.
module paralelo_serial_tx #(
  parameter int                 DATA_W    = 8,
  parameter logic [DATA_W-1:0]  COMMA     = 8'hBC,
  parameter int                 NUM_COMMA = 4
) (
  input  logic              clk,
  input  logic              reset,
  paralelo_serial_if.slave  bus
);
  localparam int               BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic {ALIGN = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] cur_byte;
  logic [BIT_W-1:0]  bit_cnt;
  logic [3:0]        comma_cnt;
  logic              cur_is_data;
  logic              data_out_q;
  logic              active_out_q;
  logic              frame_end;
  logic              comma_done;
  logic              ready;
  logic              accept;

  assign frame_end  = (bit_cnt == LAST);
  // comma_cnt saturates, so this fires exactly once per reset release
  assign comma_done = frame_end && !cur_is_data && (comma_cnt == 4'(NUM_COMMA - 1));

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ALIGN;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    if (state_q == ALIGN && comma_done) state_d = RUN;
  end

  // output logic
  always_comb begin
    ready  = frame_end && (state_q == RUN);
    accept = ready && bus.valid_in;
  end

  // serializer datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_byte     <= COMMA;
      bit_cnt      <= '0;
      comma_cnt    <= '0;
      cur_is_data  <= 1'b0;
      data_out_q   <= 1'b0;
      active_out_q <= 1'b0;
    end else begin
      data_out_q   <= cur_byte[LAST - bit_cnt];
      active_out_q <= cur_is_data;
      bit_cnt      <= bit_cnt + BIT_W'(1);
      if (frame_end) begin
        if (!cur_is_data && comma_cnt < 4'(NUM_COMMA))
          comma_cnt <= comma_cnt + 4'd1;
        if (accept) begin
          cur_byte    <= bus.data_in;
          cur_is_data <= 1'b1;
        end else begin
          cur_byte    <= COMMA;
          cur_is_data <= 1'b0;
        end
      end
    end
  end

  assign bus.ready_out  = ready;
  assign bus.data_out   = data_out_q;
  assign bus.active_out = active_out_q;
  assign bus.sync_out   = (state_q == RUN);
endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Scoreboard bench for paralelo_serial_tx: frames expected on the link are queued
// from the stimulus side and compared bit by bit by an independent monitor.
module tb_paralelo_serial_tx;
  localparam int         NUM_COMMA = 4;
  localparam logic [7:0] COMMA     = 8'hBC;

  typedef struct packed {
    logic [7:0] b;
    logic       d;
  } frame_t;

  logic clk;
  logic reset;
  paralelo_serial_if #(.DATA_W(8)) bus ();

  paralelo_serial_tx #(
    .DATA_W(8), .COMMA(COMMA), .NUM_COMMA(NUM_COMMA)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  frame_t exp_q[$];
  int     k;        // edges since reset release
  bit     started;
  int     n_chk;
  int     n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s (edge %0d): got %0h expected %0h", name, k, got, want);
    end
  endtask

  // Reference model: one link frame per 8 edges; NUM_COMMA+1 commas after release,
  // then each frame is whatever was offered at the previous frame's last bit.
  initial begin
    k = 0;
    started = 0;
    forever begin
      @(posedge clk);
      started = 1;
      if (reset) begin
        exp_q.delete();
        k = 0;
      end else begin
        if (k == 0)
          for (int i = 0; i <= NUM_COMMA; i++) exp_q.push_back('{b: COMMA, d: 1'b0});
        if (k % 8 == 7 && k >= 8 * NUM_COMMA + 7) begin
          if (bus.valid_in) exp_q.push_back('{b: bus.data_in, d: 1'b1});
          else              exp_q.push_back('{b: COMMA, d: 1'b0});
        end
        k = k + 1;
      end
    end
  end

  // Monitor: compare link outputs every cycle, away from the active edge
  initial begin
    frame_t cur;
    int     bpos;
    cur = '{b: COMMA, d: 1'b0};
    forever begin
      @(negedge clk);
      if (started) begin
        if (k == 0) begin
          chk("rst_data_out",  bus.data_out,   0);
          chk("rst_active",    bus.active_out, 0);
          chk("rst_sync",      bus.sync_out,   0);
          chk("rst_ready",     bus.ready_out,  0);
        end else begin
          bpos = (k - 1) % 8;
          if (bpos == 0) begin
            if (exp_q.size() == 0) begin
              chk("frame_underflow", 0, 1);
              cur = '{b: COMMA, d: 1'b0};
            end else begin
              cur = exp_q.pop_front();
            end
          end
          chk("data_out",   bus.data_out,   cur.b[7 - bpos]);
          chk("active_out", bus.active_out, cur.d);
          chk("sync_out",   bus.sync_out,   (k >= 8 * NUM_COMMA) ? 1 : 0);
          chk("ready_out",  bus.ready_out,
              (k % 8 == 7 && k >= 8 * NUM_COMMA + 7) ? 1 : 0);
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    bit ok;
    n  = 0;
    ok = 1;
    while (bus.ready_out !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        ok = 0;
        break;
      end
    end
    chk("ready_seen", ok, 1);
  endtask

  task automatic send(input logic [7:0] b);
    bus.data_in  = b;
    bus.valid_in = 1'b1;
    wait_ready();
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.data_in  = 8'($urandom);
  endtask

  task automatic idle_frame();
    bus.valid_in = 1'b0;
    wait_ready();
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles, input bit hold_valid, input logic [7:0] b);
    reset        = 1'b1;
    bus.valid_in = hold_valid;
    bus.data_in  = b;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    reset        = 1'b1;
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;

    // Alignment run with no data offered
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (48) @(negedge clk);

    // Back-to-back bytes, a one-frame gap, then a data byte equal to COMMA
    send(8'hFF);
    send(8'hEE);
    send(8'hDD);
    idle_frame();
    send(8'hAA);
    send(8'hBC);

    // valid held from reset release: nothing may be taken before alignment ends
    do_reset(3, 1'b1, 8'h5A);
    send(8'h5A);

    // Reset in the middle of an 0xAA frame; the byte must not reappear
    send(8'hAA);
    repeat (3) @(negedge clk);
    do_reset(2, 1'b0, 8'hAA);
    repeat (50) @(negedge clk);
    send(8'hA5);

    // Randomized traffic with gaps and occasional resets
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 11) == 0)
        do_reset($urandom_range(1, 4), 1'($urandom_range(0, 1)), 8'($urandom));
      repeat ($urandom_range(0, 2)) idle_frame();
      send(8'($urandom));
    end

    repeat (20) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/paralelo_serial_tx.md
# paralelo_serial_tx

Byte-to-bit serializer that drives the serial link consumed by the Dispositivo2 serial receiver. After reset it transmits a fixed run of COMMA bytes (0xBC) so the receiver can align and synchronize. It then forwards bytes offered by the upstream stage, MSB first, one bit per clock. Whenever no byte is offered at a frame boundary it fills the frame with COMMA, which the receiver treats as idle (its valid_out = 0).

## Interface
- COMMA, 8'hBC, idle/alignment byte.
- NUM_COMMA, 4, COMMA frames sent after reset before data is accepted; range 1..15.
- clk  input  1  bit clock; one serial bit per rising edge (the 8f clock domain).
- reset  input  1  synchronous, active-high reset, sampled on rising clk.
- data_in  input  8  byte offered by upstream.
- valid_in  input  1  data_in holds a byte to send.
- ready_out  output  1  combinational; high only in the last bit cycle of a frame, once synchronized.
- data_out  output  1  registered serial bit, MSB first.
- active_out  output  1  registered; high while data_out carries a data (non-COMMA) frame.
- sync_out  output  1  registered; high once NUM_COMMA commas are fully sent.

## Operation
- Internal state: cur_byte[7:0], bit_cnt[2:0], comma_cnt (saturates at NUM_COMMA), cur_is_data flag.
- Reset values, applied on every edge where reset=1:
  - cur_byte=COMMA, bit_cnt=0, comma_cnt=0, cur_is_data=0.
  - data_out=0, active_out=0, sync_out=0, ready_out=0.
- Each non-reset edge:
  - data_out <= cur_byte[7-bit_cnt].
  - active_out <= cur_is_data.
  - bit_cnt <= bit_cnt+1; wraps 7->0 modulo 8.
- Frame boundary (bit_cnt==7 before the edge):
  - If the ending frame is COMMA and comma_cnt<NUM_COMMA: comma_cnt+1. If it reaches NUM_COMMA, sync_out <= 1 on that edge.
  - If ready_out && valid_in: cur_byte <= data_in, cur_is_data <= 1 (byte accepted).
  - Otherwise: cur_byte <= COMMA, cur_is_data <= 0.
- ready_out = (bit_cnt==7) && sync_out. data_in and valid_in are ignored in every other cycle; upstream holds valid_in until it sees ready_out.
- A data byte equal to COMMA is sent as given. active_out=1 marks it as data.
- States, derived from the registers:
  - RESET: reset=1.
  - ALIGN: sync_out=0; only COMMA frames are sent.
  - RUN: sync_out=1; each frame is DATA or IDLE-COMMA.
  - Any state -> RESET when reset=1.
  - RESET -> ALIGN on the first edge with reset=0.
  - ALIGN -> RUN at the end of COMMA frame NUM_COMMA.
- Reset mid-frame: the frame aborts immediately and the byte in flight is lost. After reset releases, NUM_COMMA full commas are sent again before ready_out rises.

## Timing
- Edge 1 after reset deasserts drives COMMA bit7 (1). Frame k occupies edges 8k+1..8k+8.
- Default NUM_COMMA=4: sync_out rises on edge 32. Frame 4 is still COMMA.
- First ready_out: cycle before edge 40, i.e. the last bit of frame 4.
- A byte accepted at edge 40 has its bit7 on data_out at edge 41 and bit0 at edge 48.
- Sustained throughput: 1 byte per 8 clocks, no gap frames.
- ready_out pulse width: exactly 1 clk.

## Test plan
- Reset held 5 cycles, then released, valid_in=0, run 48 clocks:
  - data_out=0 during reset.
  - Then six consecutive 1,0,1,1,1,1,0,0 frames (0xBC).
  - sync_out rises at edge 32; active_out stays 0 throughout.
- valid_in=1 held with FF, EE, DD, one byte per ready_out pulse:
  - Frames after the commas are 0xFF, 0xEE, 0xDD back-to-back.
  - active_out=1 for exactly 24 bit times; ready_out pulses every 8 cycles.
- Drop valid_in after DD for one boundary, then offer AA:
  - One 0xBC frame with active_out=0, then 0xAA (10101010) with active_out=1.
- Offer data_in=0xBC as data:
  - Serial 0xBC is sent with active_out=1, distinguishing it from an idle comma.
- valid_in=1 from reset release:
  - No ready_out and no data frame before edge 40; first data bit at edge 41.
- Reset asserted on bit 3 of an 0xAA frame:
  - Outputs are zeroed the next edge.
  - After release: 4 full commas plus the frame-4 comma before ready_out.
  - The aborted byte is never resent unless upstream offers it again.
